uart_rx_fifo_wr: RTL and testbench

//   UART receive side of the serial link: 8N1 frames from rs_rx are written into the RX FIFO.

---
 rtl/uart_rx_fifo_wr.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_fifo_wr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_wr.sv
// UART 8N1 receiver that writes each good byte into a FIFO through a wr_en/full handshake.
// Bit timing is derived internally from CLKS_PER_BIT; glitch, framing and overrun events are flagged.
module uart_rx_fifo_wr #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs_rx,
    input  logic       full,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_PUSH  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [1:0]       sync_r;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             wr_en_r, wr_en_s;
    logic [7:0]       wr_data_r, wr_data_s;
    logic             busy_r, busy_s;
    logic             frame_err_r, frame_err_s;
    logic             overrun_r, overrun_s;

    assign rx_s      = sync_r[1];
    assign wr_en     = wr_en_r;
    assign wr_data   = wr_data_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

    // Next-state, datapath and next-output decode for the receive FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        shift_s     = shift_r;
        wr_en_s     = 1'b0;
        wr_data_s   = wr_data_r;
        frame_err_s = 1'b0;
        overrun_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_s = CNT_ZERO;
                idx_s = 3'd0;
                if (!rx_s) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    idx_s = 3'd0;
                    if (!rx_s) begin
                        state_s = S_DATA;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    shift_s[idx_r] = rx_s;
                    cnt_s          = CNT_ZERO;
                    idx_s          = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_s = S_STOP;
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rx_s) begin
                        state_s = S_PUSH;
                    end else begin
                        state_s     = S_BREAK;
                        frame_err_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_PUSH: begin
                state_s = S_IDLE;
                if (!full) begin
                    wr_en_s   = 1'b1;
                    wr_data_s = shift_r;
                end else begin
                    overrun_s = 1'b1;
                end
            end
            S_BREAK: begin
                // Stay here while the line is held low so a break is not read as a new frame.
                if (rx_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_BREAK;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
                idx_s   = 3'd0;
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // State, synchroniser, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            sync_r      <= 2'b11;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            wr_en_r     <= 1'b0;
            wr_data_r   <= 8'h00;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            sync_r      <= {sync_r[0], rs_rx};
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            shift_r     <= shift_s;
            wr_en_r     <= wr_en_s;
            wr_data_r   <= wr_data_s;
            busy_r      <= busy_s;
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Scoreboard bench for uart_rx_fifo_wr: frames are generated bit by bit, expected FIFO events
// are queued at send time and a negedge monitor matches every DUT pulse against the queue.
module tb_uart_rx_fifo_wr;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs_rx = 1'b1;
    logic       full = 1'b0;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo_wr #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .rs_rx(rs_rx), .full(full),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // kind: 0 = write, 1 = framing error, 2 = overrun
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         fall;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops one expectation per DUT event and checks kind, data, latency and pulse shape.
    initial begin
        logic [7:0] model_last;
        logic       prev_any;
        logic       busy_chk;
        exp_t       e;
        int         act_kind;
        int         lat;
        int         exp_lat;
        model_last = 8'h00;
        prev_any   = 1'b0;
        busy_chk   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_last = 8'h00;
            end
            if (busy_chk) begin
                check("busy_after_write", int'(busy), 0);
                busy_chk = 1'b0;
            end
            if (wr_en || frame_err || overrun) begin
                check("exclusive", $countones({wr_en, frame_err, overrun}), 1);
                check("one_cycle_pulse", int'(prev_any), 0);
                act_kind = wr_en ? 0 : (frame_err ? 1 : 2);
                if (q.size() == 0) begin
                    check("unexpected_event", act_kind, -1);
                end else begin
                    e = q.pop_front();
                    check("event_kind", act_kind, e.kind);
                    lat     = cyc - e.fall - 1;
                    exp_lat = (e.kind == 1) ? 9 * CPB + 10 : 9 * CPB + 11;
                    checks++;
                    if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
                        errors++;
                        $display("FAIL latency: got %0d expected %0d", lat, exp_lat);
                    end
                    if (e.kind == 0) begin
                        check("wr_data", int'(wr_data), int'(e.data));
                        model_last = e.data;
                        busy_chk   = 1'b1;
                    end else begin
                        check("wr_data_hold", int'(wr_data), int'(model_last));
                    end
                end
            end
            prev_any = wr_en || frame_err || overrun;
        end
    end

    // Drives one frame starting at a negedge; full_mode 0: never full, 1: full throughout,
    // 2: full during start/data bits only (released before the byte is pushed).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int full_mode);
        exp_t e;
        e.data = d;
        e.fall = cyc;
        if (!stop) begin
            e.kind = 1;
        end else if (full_mode == 1) begin
            e.kind = 2;
        end else begin
            e.kind = 0;
        end
        q.push_back(e);
        full  = (full_mode != 0);
        rs_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rs_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (full_mode == 2) full = 1'b0;
        rs_rx = stop;
        repeat (CPB) @(negedge clk);
        full  = 1'b0;
        rs_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rs_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        int         mode;
        int         guard;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_wr_data", int'(wr_data), 0);

        idle(100);
        check("idle_busy", int'(busy), 0);

        send_frame(8'hA5, 1'b1, 0);
        idle(10);

        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle(10);

        rs_rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", int'(busy), 1);
        rs_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        check("glitch_busy_low", int'(busy), 0);

        send_frame(8'h55, 1'b0, 0);
        rs_rx = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check("break_busy", int'(busy), 1);
        idle(10);
        check("break_released", int'(busy), 0);
        send_frame(8'h12, 1'b1, 0);
        idle(10);

        send_frame(8'h81, 1'b1, 1);
        idle(10);
        rs_rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rs_rx = 1'b1;
        rst   = 1'b0;
        check("midframe_rst_busy", int'(busy), 0);
        check("midframe_rst_wr_data", int'(wr_data), 0);
        idle(10);
        send_frame(8'h42, 1'b1, 0);
        idle(10);

        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            mode = $urandom_range(0, 2);
            send_frame(d, stop, mode);
            if (!stop) begin
                rs_rx = 1'b0;
                repeat ($urandom_range(0, 20)) @(negedge clk);
                idle(4);
            end
            idle($urandom_range(0, 12));
        end

        guard = 0;
        while (q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", q.size(), 0);
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
